// File: rtl/mux_rr_arb.sv
// -----------------------------------------------------------------------------
// mux_rr_arb
//
// N-input, WIDTH-bit registered selector with valid/ready handshakes on every
// input channel and on the single output. Each cycle the output register can
// take a word (it is empty or being drained), one requesting channel is
// granted. The choice is round-robin or fixed lowest-index-first, depending on
// mode. The winning word and its channel index are registered for the
// downstream consumer.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mode       0 = round-robin, 1 = fixed priority (lowest index wins)
//   in_valid   [N_IN]        per-channel request
//   in_data    [N_IN*WIDTH]  channel i occupies bits [i*WIDTH +: WIDTH]
//   in_ready   [N_IN]        per-channel accept (one-hot or zero)
//   out_valid  output register holds a word
//   out_ready  downstream accept
//   out_data   [WIDTH]       selected word
//   out_sel    [SEL_W]       index of the channel that supplied out_data
// -----------------------------------------------------------------------------
module mux_rr_arb #(
    parameter int WIDTH = 4,
    parameter int N_IN  = 4,
    parameter int SEL_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [N_IN-1:0]       in_valid,
    input  logic [N_IN*WIDTH-1:0] in_data,
    output logic [N_IN-1:0]       in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel
);

    localparam int SEL_W_REQ = (N_IN > 1) ? $clog2(N_IN) : 1;

    // Catch a mismatched index width at elaboration rather than silently
    // truncating channel numbers.
    generate
        if (SEL_W != SEL_W_REQ) begin : g_bad_sel_w
            $error("mux_rr_arb: SEL_W must be max(1, clog2(N_IN))");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [SEL_W-1:0] out_sel_reg;
    logic [SEL_W-1:0] rr_ptr_reg;
    logic [SEL_W-1:0] rr_ptr_next;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic             load;
    logic             any_req;
    logic [N_IN-1:0]  at_or_above_ptr;
    logic [N_IN-1:0]  req_hi;
    logic             found_hi;
    logic             found_lo;
    logic [SEL_W-1:0] hi_idx;
    logic [SEL_W-1:0] lo_idx;
    logic [SEL_W-1:0] grant_idx;
    logic             transfer;
    logic [WIDTH-1:0] grant_data;

    // Output register has room when empty or when it is being drained now.
    assign load    = !out_valid_reg || out_ready;
    assign any_req = |in_valid;

    // Round-robin is done as a two-pass priority search: first among channels
    // at or above rr_ptr, and if none of those request, among all channels
    // from 0 upward. That is equivalent to a circular scan starting at rr_ptr.
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_mask
            assign at_or_above_ptr[gi] = (SEL_W'(gi) >= rr_ptr_reg);
        end
    endgenerate

    assign req_hi = in_valid & at_or_above_ptr;

    always_comb begin
        found_hi = 1'b0;
        hi_idx   = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (!found_hi && req_hi[i]) begin
                found_hi = 1'b1;
                hi_idx   = SEL_W'(i);
            end
        end
    end

    // Lowest requesting index overall: the fixed-priority winner and also
    // the wrap-around winner for round-robin.
    always_comb begin
        found_lo = 1'b0;
        lo_idx   = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (!found_lo && in_valid[i]) begin
                found_lo = 1'b1;
                lo_idx   = SEL_W'(i);
            end
        end
    end

    always_comb begin
        grant_idx = lo_idx;
        if (!mode && found_hi) begin
            grant_idx = hi_idx;
        end
    end

    // rst_n gates the handshake so no channel sees an accept while reset is
    // held, even though the (empty) output register would otherwise load.
    assign transfer = rst_n && load && any_req;

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_ready
            assign in_ready[gi] = transfer && (grant_idx == SEL_W'(gi)) && in_valid[gi];
        end
    endgenerate

    assign grant_data = in_data[int'(grant_idx)*WIDTH +: WIDTH];

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (transfer && !mode) begin
            if (grant_idx == SEL_W'(N_IN - 1)) begin
                rr_ptr_next = '0;
            end else begin
                rr_ptr_next = grant_idx + SEL_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output register and round-robin pointer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
            rr_ptr_reg    <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            if (load) begin
                if (any_req) begin
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= grant_data;
                    out_sel_reg   <= grant_idx;
                end else begin
                    // Drained with nothing to replace it: data/sel keep their
                    // stale values so out_data never goes unknown.
                    out_valid_reg <= 1'b0;
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_mux_rr_arb.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arb
//
// Directed bench for mux_rr_arb: a WIDTH=4, N_IN=4 instance exercised through
// round-robin, stall, fixed priority, wrap-around, idle and mid-stall reset
// sequences, plus an N_IN=1 instance used as a plain pipeline register.
// Expected values are written by hand in each step.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mux_rr_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic [3:0]  in_valid;
    logic [15:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [1:0]  out_sel;

    logic        in_valid1;
    logic [3:0]  in_data1;
    logic        in_ready1;
    logic        out_valid1;
    logic        out_ready1;
    logic [3:0]  out_data1;
    logic        out_sel1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_rr_arb #(.WIDTH(4), .N_IN(4), .SEL_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    mux_rr_arb #(.WIDTH(4), .N_IN(1), .SEL_W(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (1'b0),
        .in_valid  (in_valid1),
        .in_data   (in_data1),
        .in_ready  (in_ready1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_data  (out_data1),
        .out_sel   (out_sel1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the registered output of the 4-channel instance.
    task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [3:0] d);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".sel"},   32'(out_sel),   32'(s));
        chk({tag, ".data"},  32'(out_data),  32'(d));
        $display("step %s: valid=%0d sel=%0d data=%h in_ready=%b", tag, out_valid, out_sel, out_data, in_ready);
    endtask

    initial begin
        // ---------------- reset state ----------------
        rst_n      = 1'b0;
        mode       = 1'b0;
        in_valid   = 4'hF;
        in_data    = 16'hDCBA;     // ch0=A ch1=B ch2=C ch3=D
        out_ready  = 1'b1;
        in_valid1  = 1'b0;
        in_data1   = 4'h0;
        out_ready1 = 1'b1;
        #2;
        chk_out("reset", 1'b0, 2'd0, 4'h0);
        chk("reset.in_ready", 32'(in_ready), 32'h0);
        chk("reset.n1.in_ready", 32'(in_ready1), 32'h0);

        // ---------------- round-robin, all requesting ----------------
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rr.first.in_ready", 32'(in_ready), 32'b0001);
        tick(); chk_out("rr0", 1'b1, 2'd0, 4'hA);
        chk("rr0.in_ready", 32'(in_ready), 32'b0010);
        tick(); chk_out("rr1", 1'b1, 2'd1, 4'hB);
        tick(); chk_out("rr2", 1'b1, 2'd2, 4'hC);
        tick(); chk_out("rr3", 1'b1, 2'd3, 4'hD);
        tick(); chk_out("rr4", 1'b1, 2'd0, 4'hA);
        tick(); chk_out("rr5", 1'b1, 2'd1, 4'hB);   // rr_ptr now 2

        // ---------------- stall holding ch1 ----------------
        out_ready = 1'b0;
        #1;
        chk("stall.in_ready", 32'(in_ready), 32'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("stall", 1'b1, 2'd1, 4'hB);
            chk("stall.in_ready_held", 32'(in_ready), 32'b0000);
        end
        out_ready = 1'b1;
        #1;
        chk("unstall.in_ready", 32'(in_ready), 32'b0100);
        tick(); chk_out("unstall", 1'b1, 2'd2, 4'hC); // rr_ptr now 3

        // ---------------- fixed priority, ch1 and ch3 requesting ----------------
        mode     = 1'b1;
        in_valid = 4'b1010;
        #1;
        chk("fixed.in_ready", 32'(in_ready), 32'b0010);
        tick(); chk_out("fixed0", 1'b1, 2'd1, 4'hB);
        tick(); chk_out("fixed1", 1'b1, 2'd1, 4'hB);
        tick(); chk_out("fixed2", 1'b1, 2'd1, 4'hB);

        // ---------------- back to round-robin: rr_ptr still 3 ----------------
        mode = 1'b0;
        #1;
        chk("rr_alt.in_ready0", 32'(in_ready), 32'b1000);
        tick(); chk_out("alt0", 1'b1, 2'd3, 4'hD);
        chk("rr_alt.in_ready1", 32'(in_ready), 32'b0010);
        tick(); chk_out("alt1", 1'b1, 2'd1, 4'hB);
        chk("rr_alt.in_ready2", 32'(in_ready), 32'b1000);
        tick(); chk_out("alt2", 1'b1, 2'd3, 4'hD);    // rr_ptr now 0

        // ---------------- wrap-around skip ----------------
        in_valid = 4'b0100;
        #1;
        chk("wrap.pre.in_ready", 32'(in_ready), 32'b0100);
        tick(); chk_out("wrap.ch2", 1'b1, 2'd2, 4'hC); // rr_ptr now 3
        in_valid = 4'b0010;
        #1;
        chk("wrap.in_ready", 32'(in_ready), 32'b0010);
        tick(); chk_out("wrap.ch1", 1'b1, 2'd1, 4'hB); // rr_ptr now 2
        in_valid = 4'b1111;
        #1;
        chk("wrap.rr_ptr2", 32'(in_ready), 32'b0100);

        // ---------------- no requests: drain ----------------
        in_valid = 4'b0000;
        in_data  = 16'h1234;        // ignored, nothing granted
        #1;
        chk("idle.in_ready", 32'(in_ready), 32'b0000);
        tick(); chk_out("idle", 1'b0, 2'd1, 4'hB);

        // ---------------- reset asserted mid-stall ----------------
        in_data  = 16'hDCBA;
        in_valid = 4'b1111;
        tick(); chk_out("pre_rst", 1'b1, 2'd2, 4'hC);
        out_ready = 1'b0;
        tick(); chk_out("pre_rst.stall", 1'b1, 2'd2, 4'hC);
        #1;
        rst_n = 1'b0;               // between edges
        #1;
        chk_out("async_rst", 1'b0, 2'd0, 4'h0);
        chk("async_rst.in_ready", 32'(in_ready), 32'b0000);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst.in_ready", 32'(in_ready), 32'b0001);
        tick(); chk_out("post_rst", 1'b1, 2'd0, 4'hA);

        // ---------------- N_IN=1 pipeline register ----------------
        in_valid1 = 1'b1;
        in_data1  = 4'h5;
        #1;
        chk("n1.in_ready", 32'(in_ready1), 32'h1);
        tick();
        chk("n1.valid", 32'(out_valid1), 32'h1);
        chk("n1.data",  32'(out_data1),  32'h5);
        chk("n1.sel",   32'(out_sel1),   32'h0);
        $display("step n1: valid=%0d data=%h", out_valid1, out_data1);
        in_data1   = 4'h9;
        out_ready1 = 1'b0;
        #1;
        chk("n1.stall.in_ready", 32'(in_ready1), 32'h0);
        tick();
        chk("n1.stall.data", 32'(out_data1), 32'h5);
        out_ready1 = 1'b1;
        tick();
        chk("n1.next.data", 32'(out_data1), 32'h9);
        $display("step n1.next: valid=%0d data=%h", out_valid1, out_data1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_rr_arb.md
Name: mux_rr_arb

Overview:
- Parametrised N-input, WIDTH-bit registered selector. Generalises the 2:1 datapath mux to N channels with valid/ready handshakes.
- Arbitrates among requesting channels, either round-robin or fixed-priority.
- Registers the winning word with its channel index for a single downstream consumer (e.g. write-back or memory-port sharing).
- One clock. Reset is asynchronous and active-low.

Parameters:
- WIDTH, 4, data bits per channel
- N_IN, 4, number of input channels (>=1)
- SEL_W, 2, width of channel index; must equal max(1, ceil(log2(N_IN)))

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- in_valid  input  N_IN  per-channel request
- in_data  input  N_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  N_IN  per-channel accept; at most one bit high
- out_valid  output  1  output register holds a word
- out_ready  input  1  downstream accept
- out_data  output  WIDTH  selected word
- out_sel  output  SEL_W  index of channel that supplied out_data

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_sel=0, rr_ptr=0, in_ready=0 combinationally while held.
- load = !out_valid || out_ready. This is the output register's capacity this cycle.
- Grant (combinational): when load=1 and any in_valid is set, exactly one channel g is granted.
  - mode=1: g is the lowest index with in_valid set.
  - mode=0: g is the first set in_valid found scanning rr_ptr, rr_ptr+1, … with wrap modulo N_IN.
- in_ready[i] = load && (i==g) && in_valid[i]. All other in_ready bits are 0.
- A transfer on channel i occurs when in_valid[i] && in_ready[i].
- On a transfer, at the next edge: out_data<=in_data[g], out_sel<=g, out_valid<=1.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word per cycle while out_ready=1.
- When load=1 and no in_valid is set: out_valid<=0 at the next edge. out_data and out_sel hold their stale values.
- Stall (out_valid=1, out_ready=0): out_data, out_sel and out_valid hold; all in_ready=0.
- rr_ptr:
  - In mode=0, on a transfer, rr_ptr <= (g==N_IN-1) ? 0 : g+1.
  - rr_ptr is unchanged in mode=1 and on cycles with no transfer.
- Mode change takes effect in the same cycle's grant. No other state is flushed.
- Inputs may drop in_valid without being granted. The block is not required to hold a request.
- in_data of a non-granted channel is ignored.
- N_IN=1: rr_ptr stays 0, g=0, and the block acts as a 1-deep pipeline register.
- Reset asserted mid-stall: the held word is discarded and out_valid=0 immediately. After release, arbitration restarts from channel 0.
- No X propagation: out_data is driven from a register at all times.

Test Plan:
- WIDTH=4, N_IN=4, mode=0, all in_valid=1, data ch0..3 = 4'hA,4'hB,4'hC,4'hD, out_ready=1 -> out_sel 0,1,2,3,0 and out_data A,B,C,D,A on consecutive cycles after 1-cycle latency.
- Stall: out_valid=1 with out_sel=1, out_ready=0 for 3 cycles -> out_data/out_sel held and in_ready=4'b0000. out_ready=1 -> next grant is ch2 in the same cycle.
- mode=1, in_valid=4'b1010, out_ready=1 -> ch1 granted every cycle and ch3 never. Switch mode=0 -> ch3 and ch1 alternate according to rr_ptr.
- mode=0, rr_ptr=3 after a ch2 grant, only in_valid[1]=1 -> ch1 granted (wrap-around skip of empty channels), then rr_ptr=2.
- No requests with out_ready=1 -> out_valid falls to 0 the next cycle, out_data holds its last value, in_ready=0.
- rst_n pulsed low mid-cycle while out_valid=1 -> out_valid, out_data, out_sel go to 0 without a clock edge. After release with all requesting, the first grant is ch0.
